varredura_teclado: RTL and testbench
====================================

# varredura_teclado

Input-side counterpart of the display scanner: scans a 4x4 multiplexed key matrix by driving one column low at a time, reads the four row lines, debounces the result and reports single key presses as a 4-bit code with a one-cycle valid strobe. It sits beside the display multiplexer on the same front panel. It feeds key events to the control FSM, replacing direct single-button inputs.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column stays driven; must be ≥ 4.
- `DEB_SCANS`, default 8: consecutive identical full-matrix scans required to accept a press or a release; must be ≥ 1.
- `clock` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `linhas` in 4: row lines, active-low, pulled up externally, asynchronous to `clock`.
- `colunas` out 4: column drive, one-hot active-low (exactly one bit 0 at all times).
- `tecla` out 4: code of the last accepted key, = 4*row + column.
- `tecla_valida` out 1: one-cycle pulse when a new key is accepted.
- `tecla_pressionada` out 1: level, high while an accepted key is held.

## Operation
- Reset values: `colunas` = 4'b1110 (column 0), `tecla` = 0, `tecla_valida` = 0, `tecla_pressionada` = 0, FSM in OCIOSO, all counters 0.
- `linhas` passes through a 2-FF synchronizer before any use.
- Slot counter counts 0..SCAN_DIV-1. On the last count it does three things:
  - samples the synchronized rows into column `col` of a 16-bit scan image (bit 4*r+c = 1 if row r is low);
  - advances `col` 0→1→2→3→0;
  - rotates `colunas`.
- Scan end is the slot end of column 3. At scan end the image is classified as one of:
  - VAZIO: no bits set.
  - UNICA(k): exactly one bit set, k = its index.
  - MULTIPLA: two or more bits set.
- The image is then cleared for the next scan.
- FSM, evaluated only at scan end:
  - OCIOSO: on UNICA(k), latch candidate k, set count = 1, go to CONFIRMANDO (if DEB_SCANS = 1, accept immediately). Otherwise stay.
  - CONFIRMANDO: UNICA(same k) increments count. When count reaches DEB_SCANS:
    - set `tecla` = k and pulse `tecla_valida`;
    - go to PRESSIONADA.
  - CONFIRMANDO, other outcomes:
    - UNICA(different k): restart with the new candidate, count = 1.
    - VAZIO or MULTIPLA: return to OCIOSO.
  - PRESSIONADA: VAZIO sets count = 1 and moves to SOLTANDO. Any non-empty image (including a different key or MULTIPLA) stays here and emits no event; there is no rollover.
  - SOLTANDO: VAZIO increments count. When count reaches DEB_SCANS, go to OCIOSO. Any non-empty image returns to PRESSIONADA with no new pulse.
- `tecla_pressionada` is high in PRESSIONADA and SOLTANDO.
- `tecla` holds its value until the next accept; it is not cleared on release.
- Asserting `reset_n` at any point, mid-scan or mid-debounce, returns every register to its reset value immediately. No pulse is emitted.

## Timing
- `colunas` changes on the clock edge that ends a slot. Rows are sampled on that same edge, so the synchronized rows have settled for at least SCAN_DIV-3 cycles.
- One full scan takes 4*SCAN_DIV cycles.
- Press-to-valid latency for a clean press: between DEB_SCANS and DEB_SCANS+1 scans after the key first closes, plus 3 cycles of synchronizer and register delay.
- `tecla` and `tecla_valida` update on the same edge. `tecla` is stable from that edge onward.
- Release-to-`tecla_pressionada`-low: DEB_SCANS to DEB_SCANS+1 scans.

## Structure
- Shared package `varredura_pkg` holds:
  - `N_LINHAS` = 4 and `N_COLUNAS` = 4;
  - the FSM state enum (OCIOSO, CONFIRMANDO, PRESSIONADA, SOLTANDO);
  - the scan classification enum (VAZIO, UNICA, MULTIPLA).
- One sub-module: `sincronizador`, a parameterized-width 2-FF synchronizer with async active-low reset to all-ones (rows idle high).
- Everything else (slot counter, column rotator, image, classifier, FSM) stays in `varredura_teclado`.

## Test plan
The bench models the matrix (row r reads low when `colunas[c]` = 0 and key (r,c) is closed) and uses SCAN_DIV = 4, DEB_SCANS = 3.
- Reset, then idle for 10 scans → `colunas` cycles 1110, 1101, 1011, 0111 at 4-cycle steps; `tecla_valida` never pulses; `tecla` = 0.
- Close key (2,1) and hold for 10 scans → exactly one `tecla_valida` pulse with `tecla` = 9, 3–4 scans after closure; `tecla_pressionada` = 1 until 3–4 scans after opening.
- Key (0,3) bounces (toggle every 5 cycles for 2 scans), then stays closed → single pulse, `tecla` = 3, no pulse during the bounce.
- Keys (1,1) and (3,2) closed together from idle → no pulse; release both and close (3,2) alone → pulse with `tecla` = 14.
- Hold key 5, close key 6 as well, then release key 5 → no second pulse while either key is held.
- Assert `reset_n` in CONFIRMANDO two scans into a press → all outputs at reset values immediately. After release, the key held through reset is re-detected with a fresh full debounce.

Source files
------------

// File: rtl/varredura_pkg.sv
// Shared types and sizes for the 4x4 key-matrix scanner.
package varredura_pkg;
  localparam int N_LINHAS  = 4;
  localparam int N_COLUNAS = 4;

  typedef enum logic [1:0] {
    OCIOSO,
    CONFIRMANDO,
    PRESSIONADA,
    SOLTANDO
  } estado_t;

  typedef enum logic [1:0] {
    VAZIO,
    UNICA,
    MULTIPLA
  } classe_t;
endpackage

// File: rtl/varredura_teclado_sincronizador.sv
// Two-flop synchronizer; resets to all-ones so idle (pulled-up) rows read as released.
module sincronizador #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_ff1;
  logic [W-1:0] r_ff2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ff1 <= '1;
      r_ff2 <= '1;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;
endmodule

// File: rtl/varredura_teclado.sv
// 4x4 key-matrix scanner: column rotation, scan image, classification and
// press/release debounce producing a one-cycle strobe per accepted key.
module varredura_teclado
  import varredura_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] linhas,
  output logic [3:0] colunas,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_pressionada,
  output estado_t    estado_dbg
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ALVO = CW'(DEB_SCANS);
  localparam logic [CW-1:0] CNT_UM   = CW'(1);

  logic [N_LINHAS-1:0] w_linhas_sync;
  logic [SW-1:0]       r_slot;
  logic [1:0]          r_col;
  logic [3:0]          r_colunas;
  logic [15:0]         r_imagem;
  logic [15:0]         w_imagem_nova;
  logic                w_fim_slot;
  logic                w_fim_varredura;
  logic [4:0]          w_qtd;
  logic [3:0]          w_chave;
  classe_t             w_classe;

  estado_t    r_estado, w_estado_prox;
  logic [CW-1:0] r_cont, w_cont_prox;
  logic [3:0] r_cand, w_cand_prox;
  logic [3:0] r_tecla, w_tecla_prox;
  logic       r_valida, w_valida_prox;

  sincronizador #(.W(N_LINHAS)) u_sinc (
    .clock  (clock),
    .reset_n(reset_n),
    .i_d    (linhas),
    .o_q    (w_linhas_sync)
  );

  assign w_fim_slot      = (r_slot == SLOT_MAX);
  assign w_fim_varredura = w_fim_slot && (r_col == 2'd3);

  // Image including the column being sampled this cycle, so the classifier
  // sees the complete matrix on the scan-end edge.
  always_comb begin
    w_imagem_nova = r_imagem;
    for (int r = 0; r < N_LINHAS; r++) begin
      for (int c = 0; c < N_COLUNAS; c++) begin
        if (c == int'(r_col)) w_imagem_nova[4*r + c] = ~w_linhas_sync[r];
      end
    end
  end

  always_comb begin
    w_qtd   = '0;
    w_chave = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_imagem_nova[i]) begin
        w_qtd   = w_qtd + 5'd1;
        w_chave = 4'(i);
      end
    end
    if (w_qtd == 5'd0)      w_classe = VAZIO;
    else if (w_qtd == 5'd1) w_classe = UNICA;
    else                    w_classe = MULTIPLA;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slot    <= '0;
      r_col     <= '0;
      r_colunas <= 4'b1110;
      r_imagem  <= '0;
    end else if (w_fim_slot) begin
      r_slot    <= '0;
      r_col     <= r_col + 2'd1;
      r_colunas <= {r_colunas[2:0], r_colunas[3]};
      r_imagem  <= w_fim_varredura ? 16'd0 : w_imagem_nova;
    end else begin
      r_slot <= r_slot + SW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
      r_cont   <= '0;
      r_cand   <= '0;
      r_tecla  <= '0;
      r_valida <= 1'b0;
    end else begin
      r_estado <= w_estado_prox;
      r_cont   <= w_cont_prox;
      r_cand   <= w_cand_prox;
      r_tecla  <= w_tecla_prox;
      r_valida <= w_valida_prox;
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_cont_prox   = r_cont;
    w_cand_prox   = r_cand;
    w_tecla_prox  = r_tecla;
    w_valida_prox = 1'b0;
    if (w_fim_varredura) begin
      case (r_estado)
        OCIOSO: begin
          if (w_classe == UNICA) begin
            w_cand_prox = w_chave;
            w_cont_prox = CNT_UM;
            if (DEB_SCANS == 1) begin
              w_tecla_prox  = w_chave;
              w_valida_prox = 1'b1;
              w_estado_prox = PRESSIONADA;
            end else begin
              w_estado_prox = CONFIRMANDO;
            end
          end
        end
        CONFIRMANDO: begin
          if (w_classe == UNICA && w_chave == r_cand) begin
            w_cont_prox = r_cont + CNT_UM;
            if (r_cont + CNT_UM == CNT_ALVO) begin
              w_tecla_prox  = r_cand;
              w_valida_prox = 1'b1;
              w_estado_prox = PRESSIONADA;
            end
          end else if (w_classe == UNICA) begin
            w_cand_prox = w_chave;
            w_cont_prox = CNT_UM;
          end else begin
            w_cont_prox   = '0;
            w_estado_prox = OCIOSO;
          end
        end
        PRESSIONADA: begin
          // Non-empty images (other key, several keys) are ignored: no rollover.
          if (w_classe == VAZIO) begin
            if (DEB_SCANS == 1) begin
              w_cont_prox   = '0;
              w_estado_prox = OCIOSO;
            end else begin
              w_cont_prox   = CNT_UM;
              w_estado_prox = SOLTANDO;
            end
          end
        end
        SOLTANDO: begin
          if (w_classe == VAZIO) begin
            if (r_cont + CNT_UM == CNT_ALVO) begin
              w_cont_prox   = '0;
              w_estado_prox = OCIOSO;
            end else begin
              w_cont_prox = r_cont + CNT_UM;
            end
          end else begin
            w_cont_prox   = '0;
            w_estado_prox = PRESSIONADA;
          end
        end
        default: w_estado_prox = OCIOSO;
      endcase
    end
  end

  assign colunas           = r_colunas;
  assign tecla             = r_tecla;
  assign tecla_valida      = r_valida;
  assign tecla_pressionada = (r_estado == PRESSIONADA) || (r_estado == SOLTANDO);
  assign estado_dbg        = r_estado;
endmodule

// File: tb/tb_varredura_teclado.sv
// Bench for varredura_teclado: matrix model on the rows, scan-level reference
// of the debounce rules, per-cycle checks of column drive and strobe.
module tb_varredura_teclado;
  import varredura_pkg::*;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_SCANS = 3;
  localparam int SCAN_LEN  = 4 * SCAN_DIV;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] linhas;
  logic [3:0] colunas;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       tecla_pressionada;
  estado_t    estado_dbg;

  logic [15:0] r_teclas = '0;

  int n_vec = 0;
  int n_err = 0;
  int n_ciclo = 0;
  int n_pulsos = 0;
  int g_bounce = 0;
  logic fase = 1'b0;

  // Reference state: run of identical single-key scans, run of empty scans.
  logic       m_held;
  int         m_run_len;
  logic [3:0] m_run_key;
  int         m_empty_run;
  logic [3:0] m_tecla;

  varredura_teclado #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .linhas           (linhas),
    .colunas          (colunas),
    .tecla            (tecla),
    .tecla_valida     (tecla_valida),
    .tecla_pressionada(tecla_pressionada),
    .estado_dbg       (estado_dbg)
  );

  always #5 clock = ~clock;

  always_comb begin
    linhas = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!colunas[c] && r_teclas[4*r + c]) linhas[r] = 1'b0;
  end

  task automatic modelo_reset();
    m_held = 1'b0; m_run_len = 0; m_run_key = '0; m_empty_run = 0; m_tecla = '0;
    n_ciclo = 0; g_bounce = 0; fase = 1'b0;
  endtask

  task automatic modelo_scan(input logic [15:0] img, output logic pulso);
    int k;
    pulso = 1'b0;
    k = 0;
    for (int i = 0; i < 16; i++) if (img[i]) k = i;
    if (!m_held) begin
      if ($countones(img) == 1) begin
        if (m_run_len > 0 && 4'(k) == m_run_key) m_run_len++;
        else begin m_run_len = 1; m_run_key = 4'(k); end
        if (m_run_len == DEB_SCANS) begin
          pulso = 1'b1; m_tecla = 4'(k); m_held = 1'b1; m_empty_run = 0;
        end
      end else m_run_len = 0;
    end else begin
      if (img == 16'd0) begin
        m_empty_run++;
        if (m_empty_run == DEB_SCANS) begin m_held = 1'b0; m_run_len = 0; end
      end else m_empty_run = 0;
    end
  endtask

  // One full scan. Column c is sampled on edge 4c+4 of the scan and, through the
  // two-flop synchronizer, sees the keys present just before edge 4c+2.
  task automatic run_scan(input logic [15:0] base, input logic [15:0] bounce);
    logic [15:0] img;
    logic [3:0]  exp_col;
    logic        pulso;
    img = '0;
    if (bounce == 16'd0) fase = 1'b0;
    r_teclas = base ^ (fase ? bounce : 16'd0);
    for (int i = 1; i <= SCAN_LEN; i++) begin
      for (int c = 0; c < 4; c++)
        if (i == 4*c + 2)
          for (int r = 0; r < 4; r++) img[4*r + c] = r_teclas[4*r + c];
      @(posedge clock);
      @(negedge clock);
      n_ciclo++;
      if (tecla_valida === 1'b1) n_pulsos++;
      exp_col = ~(4'b0001 << ((n_ciclo / SCAN_DIV) % 4));
      n_vec++;
      if (colunas !== exp_col) begin
        n_err++;
        $display("FAIL colunas ciclo %0d: got %b exp %b", n_ciclo, colunas, exp_col);
      end
      if (i < SCAN_LEN) begin
        n_vec++;
        if (tecla_valida !== 1'b0) begin
          n_err++;
          $display("FAIL valida_meio ciclo %0d: got %b exp 0", n_ciclo, tecla_valida);
        end
      end else begin
        modelo_scan(img, pulso);
        n_vec++;
        if (tecla_valida !== pulso) begin
          n_err++;
          $display("FAIL valida_fim ciclo %0d img %h: got %b exp %b", n_ciclo, img, tecla_valida, pulso);
        end
        n_vec++;
        if (tecla !== m_tecla) begin
          n_err++;
          $display("FAIL tecla ciclo %0d: got %0d exp %0d", n_ciclo, tecla, m_tecla);
        end
        n_vec++;
        if (tecla_pressionada !== m_held) begin
          n_err++;
          $display("FAIL pressionada ciclo %0d: got %b exp %b", n_ciclo, tecla_pressionada, m_held);
        end
      end
      g_bounce++;
      if (bounce != 16'd0 && (g_bounce % 5) == 0) fase = ~fase;
      r_teclas = base ^ (fase ? bounce : 16'd0);
    end
  endtask

  task automatic check_reset_vals(input string nome);
    n_vec++;
    if (colunas !== 4'b1110 || tecla !== 4'd0 || tecla_valida !== 1'b0 ||
        tecla_pressionada !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got col=%b tecla=%0d val=%b pr=%b exp col=1110 tecla=0 val=0 pr=0",
               nome, colunas, tecla, tecla_valida, tecla_pressionada);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    r_teclas = '0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset_inicial");
    reset_n = 1'b1;
    modelo_reset();
  endtask

  task automatic test_idle();
    int p0;
    p0 = n_pulsos;
    repeat (10) run_scan(16'd0, 16'd0);
    n_vec++;
    if (n_pulsos - p0 != 0) begin
      n_err++; $display("FAIL idle_pulsos: got %0d exp 0", n_pulsos - p0);
    end
  endtask

  task automatic test_single_key();
    int p0;
    p0 = n_pulsos;
    repeat (10) run_scan(16'd1 << 9, 16'd0);
    repeat (5) run_scan(16'd0, 16'd0);
    n_vec++;
    if (n_pulsos - p0 != 1 || tecla !== 4'd9) begin
      n_err++;
      $display("FAIL tecla_9: got pulsos=%0d tecla=%0d exp pulsos=1 tecla=9", n_pulsos - p0, tecla);
    end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = n_pulsos;
    fase = 1'b1;
    repeat (2) run_scan(16'd0, 16'd1 << 3);
    repeat (6) run_scan(16'd1 << 3, 16'd0);
    repeat (5) run_scan(16'd0, 16'd0);
    n_vec++;
    if (n_pulsos - p0 != 1 || tecla !== 4'd3) begin
      n_err++;
      $display("FAIL bounce_tecla_3: got pulsos=%0d tecla=%0d exp pulsos=1 tecla=3", n_pulsos - p0, tecla);
    end
  endtask

  task automatic test_two_keys();
    int p0;
    p0 = n_pulsos;
    repeat (5) run_scan((16'd1 << 5) | (16'd1 << 14), 16'd0);
    n_vec++;
    if (n_pulsos != p0) begin
      n_err++; $display("FAIL duas_teclas: got %0d pulsos exp 0", n_pulsos - p0);
    end
    run_scan(16'd0, 16'd0);
    repeat (5) run_scan(16'd1 << 14, 16'd0);
    repeat (5) run_scan(16'd0, 16'd0);
    n_vec++;
    if (tecla !== 4'd14) begin
      n_err++; $display("FAIL tecla_14: got %0d exp 14", tecla);
    end
  endtask

  task automatic test_rollover();
    int p0;
    repeat (4) run_scan(16'd1 << 5, 16'd0);
    p0 = n_pulsos;
    repeat (4) run_scan((16'd1 << 5) | (16'd1 << 6), 16'd0);
    repeat (4) run_scan(16'd1 << 6, 16'd0);
    n_vec++;
    if (n_pulsos != p0 || tecla !== 4'd5) begin
      n_err++;
      $display("FAIL rollover: got pulsos=%0d tecla=%0d exp pulsos=0 tecla=5", n_pulsos - p0, tecla);
    end
    repeat (5) run_scan(16'd0, 16'd0);
  endtask

  task automatic test_random();
    int tipo, len, k1, k2;
    for (int s = 0; s < 30; s++) begin
      tipo = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      k1   = $urandom_range(0, 15);
      k2   = (k1 + $urandom_range(1, 15)) % 16;
      case (tipo)
        0: repeat (len) run_scan(16'd0, 16'd0);
        1: repeat (len) run_scan(16'd1 << k1, 16'd0);
        2: repeat (len) run_scan((16'd1 << k1) | (16'd1 << k2), 16'd0);
        default: begin
          run_scan(16'd0, 16'd1 << k1);
          repeat (len) run_scan(16'd1 << k1, 16'd0);
        end
      endcase
    end
    repeat (5) run_scan(16'd0, 16'd0);
  endtask

  task automatic test_reset_mid();
    int k, p0;
    k = $urandom_range(1, 15);
    repeat (2) run_scan(16'd1 << k, 16'd0);
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset_meio");
    repeat (2) @(negedge clock);
    check_reset_vals("reset_mantido");
    reset_n = 1'b1;
    modelo_reset();
    p0 = n_pulsos;
    repeat (5) run_scan(16'd1 << k, 16'd0);
    n_vec++;
    if (n_pulsos - p0 != 1 || tecla !== 4'(k)) begin
      n_err++;
      $display("FAIL redeteccao: got pulsos=%0d tecla=%0d exp pulsos=1 tecla=%0d", n_pulsos - p0, tecla, k);
    end
    repeat (5) run_scan(16'd0, 16'd0);
  endtask

  initial begin
    modelo_reset();
    test_reset();
    test_idle();
    test_single_key();
    test_bounce();
    test_two_keys();
    test_rollover();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
